rs485_slave_responder: RTL and testbench
========================================

# rs485_slave_responder

Parametrised RS485 half-duplex slave that combines address detection and response transmission in one block. It receives 9-bit-mode UART frames (8 data bits, address-mark bit, stop bit) on `rx` and recognises an address frame carrying `slave_addr`. On a match it drives the bus and transmits `NUM_BYTES` data frames taken from `data_in`. It sits between the RS485 transceiver pins (RO, DI, DE) and the payload logic that supplies `data_in`.

## Interface
- `NUM_BYTES`, default 2: data frames sent per response (≥1).
- `CPB_W`, default 8: width of `clk_per_bit`.
- `TURNAROUND_BITS`, default 1: idle-high bit times with `tx_enable`=1 before the first start bit (≥1).
- `BROADCAST_EN`, default 1: if 1, address 0xFF is accepted as broadcast, which pulses `addr_match` but produces no response.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset. Single clock domain; this is already decided.
- `rx`  in  1  bus receive data (asynchronous to `clk`).
- `slave_addr`  in  8  own address.
- `clk_per_bit`  in  CPB_W  clocks per bit (≥4).
- `data_in`  in  8*NUM_BYTES  response payload; byte k = `data_in[8k+7:8k]`, byte 0 sent first.
- `tx`  out  1  bus transmit data.
- `tx_enable`  out  1  driver enable (DE).
- `tx_complete`  out  1  1-cycle pulse after the last stop bit.
- `addr_match`  out  1  1-cycle pulse when a matching address frame is received.
- `frame_err`  out  1  1-cycle pulse when a stop bit is sampled as 0.

## Operation
- `rx` passes through a 2-flop synchroniser, reset to 1. All references to rx below mean the synchronised value.
- RX FSM states: R_IDLE, R_START, R_DATA, R_MARK, R_STOP.
  - R_IDLE: on rx=0, latch `clk_per_bit` and go to R_START.
  - R_START: count to (cpb-1)>>1, then sample. rx=1 is a false start → R_IDLE. rx=0 → R_DATA.
  - R_DATA: sample every cpb cycles; 8 bits, LSB first. Then R_MARK (1 sample), then R_STOP (1 sample).
  - At the stop sample, stop=0 → `frame_err` pulse, no match, R_IDLE.
  - At the stop sample, stop=1, mark=1, byte==`slave_addr` → `addr_match` pulse.
  - At the stop sample, stop=1, mark=1, byte==0xFF with BROADCAST_EN → `addr_match` pulse, no TX.
  - mark=0 frames are ignored silently.
- While `tx_enable`=1 the receiver is held in R_IDLE. This suppresses echo.
- TX FSM states: T_IDLE, T_TURN, T_FRAME, T_DONE.
  - On a non-broadcast `addr_match`, capture `data_in` and `clk_per_bit` into shadow registers, set `tx_enable`=1 and `tx`=1, and enter T_TURN for TURNAROUND_BITS·cpb cycles.
  - T_FRAME sends each byte as 11 bit times: start 0, 8 data bits LSB first, mark 0, stop 1. A byte counter runs 0..NUM_BYTES-1; a bit counter runs 0..10.
  - After the last stop bit: T_DONE for 1 cycle, where `tx_enable`←0 and `tx_complete`=1, then T_IDLE.
- Changes to `data_in` or `clk_per_bit` during a response have no effect. Changes to `clk_per_bit` mid-RX-frame have no effect.
- `tx`=1 whenever it is not in a start/data/mark bit.

## Timing
- Reset values: `tx`=1, `tx_enable`=0, `tx_complete`=0, `addr_match`=0, `frame_err`=0, both FSMs idle, all counters 0. Reset takes effect immediately, including mid-frame or mid-response; no `tx_complete` is issued for an aborted response.
- Address-frame latency: the stop bit is sampled at (cpb-1)>>1 + 10·cpb cycles after the synchronised falling edge. `addr_match` asserts the cycle after that sample.
- `tx_enable` rises the cycle after `addr_match` and stays high for exactly cpb·(TURNAROUND_BITS + 11·NUM_BYTES) cycles. `tx_complete` pulses in the cycle `tx_enable` falls.
- Bit counters are CPB_W bits wide and compare against cpb-1. They wrap to 0 at each bit boundary.
- An `addr_match` while the TX FSM is not idle cannot occur, because RX is gated. If `tx_enable` and an RX start edge coincide, the gating wins.
- A start edge arriving back-to-back with the previous stop sample is accepted; there is no mandatory idle gap on RX.

## Test plan
Parameters: defaults, cpb=8, `slave_addr`=0x02, `data_in`=0xA55A.
1. Frame 0x02 with mark=1 → `addr_match` ×1. `tx_enable` high 184 cycles. `tx` idles 8 cycles, then 0,0,1,0,1,1,0,1,0,0,1 (0x5A), then 0,1,0,1,0,0,1,0,1,0,1 (0xA5), each bit 8 cycles wide. `tx_complete` ×1 at the fall.
2. Frame 0x03 with mark=1, then 0x02 with mark=0 → no `addr_match`, `tx_enable` stays 0, `frame_err` stays 0.
3. Frame 0x02 with the stop bit forced to 0 → `frame_err` ×1, no `addr_match`, no TX. A following valid 0x02 frame is served normally.
4. `rx` low for 3 cycles, then high → no frame, no pulses. Frame 0xFF with mark=1 → `addr_match` ×1 and `tx_enable` stays 0.
5. Assert `rst` 50 cycles into the response of case 1 → `tx`=1 and `tx_enable`=0 immediately, and no `tx_complete`. After release, a new 0x02 frame yields the full case-1 waveform.
6. Drive `rx` toggling while `tx_enable`=1 → no `addr_match`/`frame_err`. Change `data_in` mid-response → the transmitted bytes remain 0x5A and 0xA5.

Source files
------------

// File: rtl/rs485_slave_responder.sv
// RS485 half-duplex slave: receives 9-bit-mode UART frames (8 data, address
// mark, stop) and answers a matching address frame with NUM_BYTES data frames.
// Ports:
//   clk, rst (async active-low)      clock / reset
//   rx                                bus receive data (asynchronous)
//   slave_addr[7:0]                   own address
//   clk_per_bit[CPB_W-1:0]            clocks per bit time (>= 4)
//   data_in[8*NUM_BYTES-1:0]          response payload, byte 0 sent first
//   tx, tx_enable                     bus transmit data / driver enable
//   tx_complete, addr_match, frame_err  single-cycle status pulses
module rs485_slave_responder #(
    parameter int unsigned NUM_BYTES       = 2,
    parameter int unsigned CPB_W           = 8,
    parameter int unsigned TURNAROUND_BITS = 1,
    parameter bit          BROADCAST_EN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx,
    input  logic [7:0]             slave_addr,
    input  logic [CPB_W-1:0]       clk_per_bit,
    input  logic [8*NUM_BYTES-1:0] data_in,
    output logic                   tx,
    output logic                   tx_enable,
    output logic                   tx_complete,
    output logic                   addr_match,
    output logic                   frame_err
);

    localparam int unsigned BYTE_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned TURN_W = (TURNAROUND_BITS > 1) ? $clog2(TURNAROUND_BITS) : 1;

    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_MARK, R_STOP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_TURN, T_FRAME, T_DONE} tx_state_t;

    logic                   rx_meta, rx_s;
    rx_state_t              rx_state;
    logic [CPB_W-1:0]       rx_cpb, rx_cnt;
    logic [2:0]             rx_bit;
    logic [7:0]             rx_byte;
    logic                   rx_mark;
    logic                   resp_req;

    tx_state_t              tx_state;
    logic [CPB_W-1:0]       tx_cpb, tx_cnt;
    logic [TURN_W-1:0]      tx_turn;
    logic [3:0]             tx_bit;
    logic [BYTE_W-1:0]      tx_byte_idx;
    logic [8*NUM_BYTES-1:0] tx_shadow;
    logic [7:0]             tx_cur;

    logic [CPB_W-1:0]       rx_half_c;
    logic                   rx_tick_c, tx_tick_c;

    assign rx_half_c = (rx_cpb - CPB_W'(1)) >> 1;
    assign rx_tick_c = (rx_cnt == rx_cpb - CPB_W'(1));
    assign tx_tick_c = (tx_cnt == tx_cpb - CPB_W'(1));

    // Two-flop synchroniser, idles high like the bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receiver FSM; held idle while we drive the bus so our own echo is ignored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= R_IDLE;
            rx_cpb     <= '0;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_byte    <= '0;
            rx_mark    <= 1'b0;
            resp_req   <= 1'b0;
            addr_match <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            addr_match <= 1'b0;
            frame_err  <= 1'b0;
            resp_req   <= 1'b0;
            if (tx_enable) begin
                rx_state <= R_IDLE;
                rx_cnt   <= '0;
            end else begin
                case (rx_state)
                    R_IDLE: begin
                        if (!rx_s) begin
                            rx_cpb   <= clk_per_bit;
                            rx_cnt   <= '0;
                            rx_state <= R_START;
                        end
                    end
                    R_START: begin
                        // Mid-start-bit check rejects glitches
                        if (rx_cnt == rx_half_c) begin
                            rx_cnt   <= '0;
                            rx_bit   <= '0;
                            rx_state <= rx_s ? R_IDLE : R_DATA;
                        end else begin
                            rx_cnt <= rx_cnt + CPB_W'(1);
                        end
                    end
                    R_DATA: begin
                        if (rx_tick_c) begin
                            rx_cnt  <= '0;
                            rx_byte <= {rx_s, rx_byte[7:1]};
                            rx_bit  <= rx_bit + 3'd1;
                            if (rx_bit == 3'd7) begin
                                rx_state <= R_MARK;
                            end
                        end else begin
                            rx_cnt <= rx_cnt + CPB_W'(1);
                        end
                    end
                    R_MARK: begin
                        if (rx_tick_c) begin
                            rx_cnt   <= '0;
                            rx_mark  <= rx_s;
                            rx_state <= R_STOP;
                        end else begin
                            rx_cnt <= rx_cnt + CPB_W'(1);
                        end
                    end
                    R_STOP: begin
                        if (rx_tick_c) begin
                            rx_cnt   <= '0;
                            rx_state <= R_IDLE;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                            end else if (rx_mark) begin
                                // Broadcast is acknowledged but never answered
                                if (BROADCAST_EN && rx_byte == 8'hFF) begin
                                    addr_match <= 1'b1;
                                end else if (rx_byte == slave_addr) begin
                                    addr_match <= 1'b1;
                                    resp_req   <= 1'b1;
                                end
                            end
                        end else begin
                            rx_cnt <= rx_cnt + CPB_W'(1);
                        end
                    end
                    default: rx_state <= R_IDLE;
                endcase
            end
        end
    end

    // Transmitter FSM: turnaround idle, then start/data/mark(0)/stop per byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state    <= T_IDLE;
            tx          <= 1'b1;
            tx_enable   <= 1'b0;
            tx_complete <= 1'b0;
            tx_cpb      <= '0;
            tx_cnt      <= '0;
            tx_turn     <= '0;
            tx_bit      <= '0;
            tx_byte_idx <= '0;
            tx_shadow   <= '0;
            tx_cur      <= '0;
        end else begin
            tx_complete <= 1'b0;
            case (tx_state)
                T_IDLE: begin
                    if (resp_req) begin
                        tx_shadow <= data_in;
                        tx_cpb    <= clk_per_bit;
                        tx_cnt    <= '0;
                        tx_turn   <= '0;
                        tx_enable <= 1'b1;
                        tx        <= 1'b1;
                        tx_state  <= T_TURN;
                    end
                end
                T_TURN: begin
                    if (tx_tick_c) begin
                        tx_cnt <= '0;
                        if (tx_turn == TURN_W'(TURNAROUND_BITS - 1)) begin
                            tx_state    <= T_FRAME;
                            tx          <= 1'b0;
                            tx_bit      <= '0;
                            tx_byte_idx <= '0;
                            tx_cur      <= tx_shadow[7:0];
                            tx_shadow   <= tx_shadow >> 8;
                        end else begin
                            tx_turn <= tx_turn + TURN_W'(1);
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CPB_W'(1);
                    end
                end
                T_FRAME: begin
                    if (tx_tick_c) begin
                        tx_cnt <= '0;
                        if (tx_bit == 4'd10) begin
                            if (tx_byte_idx == BYTE_W'(NUM_BYTES - 1)) begin
                                tx_state    <= T_DONE;
                                tx          <= 1'b1;
                                tx_enable   <= 1'b0;
                                tx_complete <= 1'b1;
                            end else begin
                                tx_byte_idx <= tx_byte_idx + BYTE_W'(1);
                                tx_bit      <= '0;
                                tx          <= 1'b0;
                                tx_cur      <= tx_shadow[7:0];
                                tx_shadow   <= tx_shadow >> 8;
                            end
                        end else begin
                            tx_bit <= tx_bit + 4'd1;
                            // tx_bit is the bit just finished; drive the next one
                            if (tx_bit < 4'd8) begin
                                tx     <= tx_cur[0];
                                tx_cur <= tx_cur >> 1;
                            end else if (tx_bit == 4'd8) begin
                                tx <= 1'b0;
                            end else begin
                                tx <= 1'b1;
                            end
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CPB_W'(1);
                    end
                end
                T_DONE: tx_state <= T_IDLE;
                default: tx_state <= T_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs485_slave_responder.sv
// Self-checking bench for rs485_slave_responder: directed cases plus random
// frames, checked against a per-cycle waveform model of the expected response.
module tb_rs485_slave_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic [7:0]  slave_addr = 8'h02;
    logic [7:0]  clk_per_bit = 8'd8;
    logic [15:0] data_in = 16'hA55A;
    logic        tx, tx_enable, tx_complete, addr_match, frame_err;

    rs485_slave_responder dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .slave_addr (slave_addr),
        .clk_per_bit(clk_per_bit),
        .data_in    (data_in),
        .tx         (tx),
        .tx_enable  (tx_enable),
        .tx_complete(tx_complete),
        .addr_match (addr_match),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge
    logic resp_q[$];
    logic exp_q[$];
    int   match_cnt = 0, ferr_cnt = 0, txc_cnt = 0, fall_cnt = 0;
    logic en_prev = 1'b0, match_prev = 1'b0;
    bit   skip_fall = 1'b0;

    always @(negedge clk) begin
        if (tx_enable === 1'b1) resp_q.push_back(tx);
        if (addr_match === 1'b1) match_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if (tx_complete === 1'b1) txc_cnt++;
        if (tx_enable === 1'b1 && en_prev === 1'b0)
            chk("match_before_en", 32'(match_prev), 32'd1);
        if (tx_enable === 1'b0 && en_prev === 1'b1) begin
            fall_cnt++;
            if (!skip_fall) chk("txc_at_fall", 32'(tx_complete), 32'd1);
        end
        en_prev    = tx_enable;
        match_prev = addr_match;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: one turnaround bit of idle high, then per byte
    // start 0, 8 data bits LSB first, mark 0, stop 1; each bit cpb cycles
    function automatic void build_exp(input logic [15:0] d, input int cpb);
        logic [7:0] b;
        logic       v;
        exp_q.delete();
        for (int i = 0; i < cpb; i++) exp_q.push_back(1'b1);
        for (int k = 0; k < 2; k++) begin
            b = 8'(d >> (8 * k));
            for (int j = 0; j < 11; j++) begin
                if (j == 0)      v = 1'b0;
                else if (j <= 8) v = b[j-1];
                else if (j == 9) v = 1'b0;
                else             v = 1'b1;
                for (int c = 0; c < cpb; c++) exp_q.push_back(v);
            end
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic mark, input logic stop, input int cpb);
        logic [10:0] bits;
        bits = {stop, mark, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = bits[i];
            tick(cpb);
        end
        rx = 1'b1;
    endtask

    task automatic run_txn(input string tag, input logic [7:0] b, input logic mark, input logic stop,
                           input int cpb, input bit exp_match, input bit exp_resp, input bit exp_ferr,
                           input bit noisy, input bit reset_mid);
        int m0, f0, t0, fc0, cyc, diffs;
        m0 = match_cnt; f0 = ferr_cnt; t0 = txc_cnt; fc0 = fall_cnt;
        clk_per_bit = 8'(cpb);
        resp_q.delete();
        if (exp_resp) build_exp(data_in, cpb);
        send_frame(b, mark, stop, cpb);
        if (exp_resp) begin
            cyc = 0;
            while (fall_cnt == fc0 && cyc < 2000) begin
                if (noisy) begin
                    rx = (tx_enable && resp_q.size() + 8 < exp_q.size()) ? 1'($urandom) : 1'b1;
                    if (resp_q.size() == 40) data_in = 16'($urandom);
                end
                if (reset_mid && resp_q.size() >= 50) begin
                    skip_fall = 1'b1;
                    rst = 1'b0;
                    #1;
                    chk({tag, "_rst_tx"}, 32'(tx), 32'd1);
                    chk({tag, "_rst_en"}, 32'(tx_enable), 32'd0);
                    chk({tag, "_rst_txc"}, 32'(tx_complete), 32'd0);
                    tick(3);
                    rst = 1'b1;
                    tick(1);
                    skip_fall = 1'b0;
                    break;
                end
                tick(1);
                cyc++;
            end
            rx = 1'b1;
            if (reset_mid) begin
                tick(30 * cpb);
                chk({tag, "_no_txc"}, 32'(txc_cnt - t0), 32'd0);
            end else begin
                chk({tag, "_timeout"}, 32'(cyc < 2000), 32'd1);
                chk({tag, "_en_len"}, 32'(resp_q.size()), 32'(exp_q.size()));
                diffs = 0;
                for (int i = 0; i < exp_q.size() && i < resp_q.size(); i++)
                    if (resp_q[i] !== exp_q[i]) diffs++;
                chk({tag, "_wave_diffs"}, 32'(diffs), 32'd0);
                chk({tag, "_txc"}, 32'(txc_cnt - t0), 32'd1);
            end
        end else begin
            tick(4 * cpb);
            chk({tag, "_no_resp"}, 32'(resp_q.size()), 32'd0);
        end
        chk({tag, "_match"}, 32'(match_cnt - m0), 32'(exp_match));
        chk({tag, "_ferr"}, 32'(ferr_cnt - f0), 32'(exp_ferr));
        tick(2 * cpb);
    endtask

    initial begin
        int m0, f0, kind, cpb;
        logic [7:0] b;
        #1 rst = 1'b0;
        tick(3);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_en", 32'(tx_enable), 32'd0);
        chk("rst_txc", 32'(tx_complete), 32'd0);
        chk("rst_match", 32'(addr_match), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        rst = 1'b1;
        tick(5);

        run_txn("c1", 8'h02, 1'b1, 1'b1, 8, 1, 1, 0, 0, 0);
        run_txn("c2_other", 8'h03, 1'b1, 1'b1, 8, 0, 0, 0, 0, 0);
        run_txn("c2_nomark", 8'h02, 1'b0, 1'b1, 8, 0, 0, 0, 0, 0);
        run_txn("c3_badstop", 8'h02, 1'b1, 1'b0, 8, 0, 0, 1, 0, 0);
        run_txn("c3_after", 8'h02, 1'b1, 1'b1, 8, 1, 1, 0, 0, 0);

        m0 = match_cnt; f0 = ferr_cnt;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(40);
        chk("c4_glitch_match", 32'(match_cnt - m0), 32'd0);
        chk("c4_glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        chk("c4_glitch_en", 32'(tx_enable), 32'd0);
        run_txn("c4_bcast", 8'hFF, 1'b1, 1'b1, 8, 1, 0, 0, 0, 0);

        run_txn("c5_reset", 8'h02, 1'b1, 1'b1, 8, 1, 1, 0, 0, 1);
        run_txn("c5_after", 8'h02, 1'b1, 1'b1, 8, 1, 1, 0, 0, 0);
        run_txn("c6_noisy", 8'h02, 1'b1, 1'b1, 8, 1, 1, 0, 1, 0);

        for (int it = 0; it < 24; it++) begin
            cpb = $urandom_range(6, 16);
            do slave_addr = 8'($urandom); while (slave_addr == 8'hFF);
            data_in = 16'($urandom);
            kind = $urandom_range(0, 4);
            case (kind)
                0: run_txn("r_match", slave_addr, 1'b1, 1'b1, cpb, 1, 1, 0, 0, 0);
                1: begin
                    do b = 8'($urandom); while (b == slave_addr || b == 8'hFF);
                    run_txn("r_other", b, 1'b1, 1'b1, cpb, 0, 0, 0, 0, 0);
                end
                2: begin
                    b = 8'($urandom);
                    run_txn("r_data", b, 1'b0, 1'b1, cpb, 0, 0, 0, 0, 0);
                end
                3: run_txn("r_badstop", slave_addr, 1'b1, 1'b0, cpb, 0, 0, 1, 0, 0);
                default: run_txn("r_bcast", 8'hFF, 1'b1, 1'b1, cpb, 1, 0, 0, 0, 0);
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
